// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the GPIO input conditioning stage and the
// GPIO block it feeds, so that pin count and debounce widths always agree.
//   GPIO_N        default number of GPIO pins
//   GPIO_DEB_W    default debounce counter width
//   GPIO_DEB_CNT  default stable cycles needed to accept a new level
//   deb_act_e     per-cycle action taken by a pin's debounce logic
package gpio_pkg;

    localparam int GPIO_N       = 8;
    localparam int GPIO_DEB_W   = 4;
    localparam int GPIO_DEB_CNT = 10;

    typedef enum logic [1:0] {
        DEB_HOLD   = 2'd0,  // input agrees with stable level, counter idle
        DEB_COUNT  = 2'd1,  // input differs, still accumulating stable cycles
        DEB_ACCEPT = 2'd2,  // input differed long enough, take the new level
        DEB_BYPASS = 2'd3   // debounce disabled, follow the synchroniser
    } deb_act_e;

    // True when a debounce count is representable by a DEB_W-bit counter.
    function automatic logic deb_cnt_legal(input int cnt, input int width);
        return (cnt >= 1) && (cnt <= (1 << width));
    endfunction

endpackage

// File: rtl/gpio_in_chk.sv
// gpio_in_chk: elaboration-time parameter check for the input conditioner.
// No ports; instantiated once by gpio_in_cond.
//   DEB_W    debounce counter width
//   DEB_CNT  stable cycles required (legal 1 .. 2**DEB_W)
module gpio_in_chk
    import gpio_pkg::*;
#(
    parameter int DEB_W   = GPIO_DEB_W,
    parameter int DEB_CNT = GPIO_DEB_CNT
) ();

    if (!deb_cnt_legal(DEB_CNT, DEB_W)) begin : g_bad_deb_cnt
        $error("gpio_in_chk: DEB_CNT=%0d outside 1..2**DEB_W (DEB_W=%0d)", DEB_CNT, DEB_W);
    end

endmodule

// File: rtl/gpio_in_pin.sv
// gpio_in_pin: conditioning for a single GPIO pin.
//   clk, reset_n  clock and asynchronous active-low reset
//   pin_in        raw asynchronous pad level
//   deb_en        1 = debounce, 0 = bypass (follow synchroniser)
//   irq_rise_en   arm status on rising edge of the conditioned level
//   irq_fall_en   arm status on falling edge of the conditioned level
//   irq_clr       write-1-to-clear for the status bit
//   gpio_in       conditioned level
//   rise_pulse    one-cycle pulse in the first cycle gpio_in reads 1
//   fall_pulse    one-cycle pulse in the first cycle gpio_in reads 0
//   irq_status    sticky interrupt flag
module gpio_in_pin
    import gpio_pkg::*;
#(
    parameter int DEB_W   = GPIO_DEB_W,
    parameter int DEB_CNT = GPIO_DEB_CNT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_in,
    input  logic deb_en,
    input  logic irq_rise_en,
    input  logic irq_fall_en,
    input  logic irq_clr,
    output logic gpio_in,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic irq_status
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);
    localparam logic [DEB_W-1:0] DEB_ZERO = DEB_W'(0);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic [DEB_W-1:0] cnt_r;
    logic             rise_r;
    logic             fall_r;
    logic             status_r;

    deb_act_e         act_s;
    logic             stable_nxt_s;
    logic [DEB_W-1:0] cnt_nxt_s;
    logic             status_nxt_s;

    // Two-flop synchroniser, nothing between the flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pin_in;
            sync2_r <= sync1_r;
        end
    end

    // Classify this cycle's debounce action.
    always_comb begin
        act_s = DEB_HOLD;
        if (!deb_en) begin
            act_s = DEB_BYPASS;
        end else if (sync2_r == stable_r) begin
            act_s = DEB_HOLD;
        end else if (cnt_r == DEB_LAST) begin
            act_s = DEB_ACCEPT;
        end else begin
            act_s = DEB_COUNT;
        end
    end

    // Next stable level and counter from the chosen action; a glitch back to
    // the stable level lands in DEB_HOLD and so restarts the count.
    always_comb begin
        stable_nxt_s = stable_r;
        cnt_nxt_s    = DEB_ZERO;
        case (act_s)
            DEB_BYPASS: begin
                stable_nxt_s = sync2_r;
                cnt_nxt_s    = DEB_ZERO;
            end
            DEB_HOLD: begin
                stable_nxt_s = stable_r;
                cnt_nxt_s    = DEB_ZERO;
            end
            DEB_COUNT: begin
                stable_nxt_s = stable_r;
                cnt_nxt_s    = cnt_r + DEB_ONE;
            end
            DEB_ACCEPT: begin
                stable_nxt_s = sync2_r;
                cnt_nxt_s    = DEB_ZERO;
            end
            default: begin
                stable_nxt_s = stable_r;
                cnt_nxt_s    = DEB_ZERO;
            end
        endcase
    end

    // Sticky status: a new enabled event beats a simultaneous clear.
    always_comb begin
        status_nxt_s = (rise_r & irq_rise_en) | (fall_r & irq_fall_en) | (status_r & ~irq_clr);
    end

    // Stable level, counter and edge pulses; pulses are computed from the
    // next level so they coincide with the first cycle the new level shows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_r <= 1'b0;
            cnt_r    <= DEB_ZERO;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
        end else begin
            stable_r <= stable_nxt_s;
            cnt_r    <= cnt_nxt_s;
            rise_r   <= stable_nxt_s & ~stable_r;
            fall_r   <= ~stable_nxt_s & stable_r;
        end
    end

    // Interrupt status register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status_r <= 1'b0;
        end else begin
            status_r <= status_nxt_s;
        end
    end

    assign gpio_in    = stable_r;
    assign rise_pulse = rise_r;
    assign fall_pulse = fall_r;
    assign irq_status = status_r;

endmodule

// File: rtl/gpio_in_cond.sv
// gpio_in_cond: input conditioning in front of the GPIO block. Each of the N
// pins is synchronised, optionally debounced, edge-detected and given a
// sticky interrupt flag; the flags are ORed into a single irq line.
//   clk, reset_n  clock and asynchronous active-low reset
//   pin_in        raw pad levels (asynchronous)
//   deb_en        per-pin debounce enable
//   irq_rise_en   per-pin rising-edge interrupt enable
//   irq_fall_en   per-pin falling-edge interrupt enable
//   irq_clr       per-pin write-1-to-clear of irq_status
//   gpio_in       conditioned levels
//   rise_pulse    per-pin rising-edge pulse
//   fall_pulse    per-pin falling-edge pulse
//   irq_status    sticky per-pin interrupt flags
//   irq           OR of irq_status
module gpio_in_cond
    import gpio_pkg::*;
#(
    parameter int N       = GPIO_N,
    parameter int DEB_W   = GPIO_DEB_W,
    parameter int DEB_CNT = GPIO_DEB_CNT
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] pin_in,
    input  logic [N-1:0] deb_en,
    input  logic [N-1:0] irq_rise_en,
    input  logic [N-1:0] irq_fall_en,
    input  logic [N-1:0] irq_clr,
    output logic [N-1:0] gpio_in,
    output logic [N-1:0] rise_pulse,
    output logic [N-1:0] fall_pulse,
    output logic [N-1:0] irq_status,
    output logic         irq
);

    gpio_in_chk #(
        .DEB_W   (DEB_W),
        .DEB_CNT (DEB_CNT)
    ) u_chk ();

    for (genvar i = 0; i < N; i++) begin : g_pin
        gpio_in_pin #(
            .DEB_W   (DEB_W),
            .DEB_CNT (DEB_CNT)
        ) u_pin (
            .clk         (clk),
            .reset_n     (reset_n),
            .pin_in      (pin_in[i]),
            .deb_en      (deb_en[i]),
            .irq_rise_en (irq_rise_en[i]),
            .irq_fall_en (irq_fall_en[i]),
            .irq_clr     (irq_clr[i]),
            .gpio_in     (gpio_in[i]),
            .rise_pulse  (rise_pulse[i]),
            .fall_pulse  (fall_pulse[i]),
            .irq_status  (irq_status[i])
        );
    end

    // Aggregated interrupt, combinational from the registered flags.
    always_comb begin
        irq = |irq_status;
    end

endmodule

// File: tb/tb_gpio_in_cond.sv
// tb_gpio_in_cond: directed bench for gpio_in_cond (N=8, DEB_CNT=10).
// Expectations are queued with the cycle they fall due when stimulus is
// applied, and checked as the clock reaches that cycle.
module tb_gpio_in_cond;

    localparam int S_GPIO = 0;
    localparam int S_RISE = 1;
    localparam int S_FALL = 2;
    localparam int S_STAT = 3;
    localparam int S_IRQ  = 4;

    logic       clk;
    logic       reset_n;
    logic [7:0] pin_in;
    logic [7:0] deb_en;
    logic [7:0] irq_rise_en;
    logic [7:0] irq_fall_en;
    logic [7:0] irq_clr;
    logic [7:0] gpio_in;
    logic [7:0] rise_pulse;
    logic [7:0] fall_pulse;
    logic [7:0] irq_status;
    logic       irq;

    typedef struct {
        string      tag;
        int         due;
        int         sel;
        logic [7:0] mask;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cycle   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    gpio_in_cond #(.N(8), .DEB_W(4), .DEB_CNT(10)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pin_in      (pin_in),
        .deb_en      (deb_en),
        .irq_rise_en (irq_rise_en),
        .irq_fall_en (irq_fall_en),
        .irq_clr     (irq_clr),
        .gpio_in     (gpio_in),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .irq_status  (irq_status),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] obs_of(input int sel);
        case (sel)
            S_GPIO:  return gpio_in;
            S_RISE:  return rise_pulse;
            S_FALL:  return fall_pulse;
            S_STAT:  return irq_status;
            S_IRQ:   return {7'b0000000, irq};
            default: return 8'hxx;
        endcase
    endfunction

    task automatic check(input string tag, input int sel, input logic [7:0] mask, input logic [7:0] exp);
        logic [7:0] obs;
        obs = obs_of(sel) & mask;
        n_tests++;
        assert (obs === (exp & mask)) else begin
            n_fail++;
            $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cycle, obs, exp & mask);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [7:0] mask,
                        input logic [7:0] exp, input int dly);
        exp_t e;
        e.tag  = tag;
        e.due  = cycle + dly;
        e.sel  = sel;
        e.mask = mask;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Advance one clock, sample 1 ns after the edge, retire due expectations.
    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cycle) begin
                check(sb[i].tag, sb[i].sel, sb[i].mask, sb[i].exp);
                sb.delete(i);
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        reset_n     = 1'b0;
        pin_in      = 8'h00;
        deb_en      = 8'hFF;
        irq_rise_en = 8'h00;
        irq_fall_en = 8'h00;
        irq_clr     = 8'h00;

        // 1. Reset state and quiet period after release.
        #2;
        check("rst_gpio", S_GPIO, 8'hFF, 8'h00);
        check("rst_stat", S_STAT, 8'hFF, 8'h00);
        check("rst_irq",  S_IRQ,  8'h01, 8'h00);
        run(3);
        reset_n = 1'b1;
        for (int d = 1; d <= 50; d++) begin
            push("t1_gpio", S_GPIO, 8'hFF, 8'h00, d);
            push("t1_rise", S_RISE, 8'hFF, 8'h00, d);
            push("t1_fall", S_FALL, 8'hFF, 8'h00, d);
            push("t1_stat", S_STAT, 8'hFF, 8'h00, d);
            push("t1_irq",  S_IRQ,  8'h01, 8'h00, d);
        end
        run(50);

        // 2. Debounced rise on pin 0: visible 12 clocks after the change.
        irq_rise_en = 8'h01;
        pin_in[0]   = 1'b1;
        push("t2_gpio_early", S_GPIO, 8'h01, 8'h00, 11);
        push("t2_rise_early", S_RISE, 8'h01, 8'h00, 11);
        push("t2_gpio",       S_GPIO, 8'h01, 8'h01, 12);
        push("t2_rise",       S_RISE, 8'h01, 8'h01, 12);
        push("t2_fall",       S_FALL, 8'h01, 8'h00, 12);
        push("t2_stat_early", S_STAT, 8'h01, 8'h00, 12);
        push("t2_rise_end",   S_RISE, 8'h01, 8'h00, 13);
        push("t2_stat",       S_STAT, 8'hFF, 8'h01, 13);
        push("t2_irq",        S_IRQ,  8'h01, 8'h01, 13);
        push("t2_stat_hold",  S_STAT, 8'hFF, 8'h01, 20);
        push("t2_irq_hold",   S_IRQ,  8'h01, 8'h01, 20);
        run(22);

        // 3. Six-cycle glitch on pin 3 is rejected.
        pin_in[3] = 1'b1;
        run(6);
        pin_in[3] = 1'b0;
        for (int d = 1; d <= 20; d++) begin
            push("t3_gpio", S_GPIO, 8'h08, 8'h00, d);
            push("t3_rise", S_RISE, 8'h08, 8'h00, d);
            push("t3_fall", S_FALL, 8'h08, 8'h00, d);
            push("t3_stat", S_STAT, 8'hFF, 8'h01, d);
        end
        run(20);

        // 4. Bypass on pin 5: 3-clock path, fall pulse, fall irq disabled.
        deb_en    = 8'hDF;
        pin_in[5] = 1'b1;
        push("t4_up_early", S_GPIO, 8'h20, 8'h00, 2);
        push("t4_up",       S_GPIO, 8'h20, 8'h20, 3);
        push("t4_up_rise",  S_RISE, 8'h20, 8'h20, 3);
        push("t4_up_stat",  S_STAT, 8'h20, 8'h00, 4);
        run(6);
        pin_in[5] = 1'b0;
        push("t4_dn_early", S_GPIO, 8'h20, 8'h20, 2);
        push("t4_dn",       S_GPIO, 8'h20, 8'h00, 3);
        push("t4_fall",     S_FALL, 8'h20, 8'h20, 3);
        push("t4_fall_rise",S_RISE, 8'h20, 8'h00, 3);
        push("t4_fall_end", S_FALL, 8'h20, 8'h00, 4);
        for (int d = 4; d <= 6; d++) push("t4_stat", S_STAT, 8'hFF, 8'h01, d);
        run(8);

        // 5. Disabling an enable keeps status; set wins over clear.
        irq_rise_en = 8'h04;
        pin_in[2]   = 1'b1;
        push("t5_keep0",     S_STAT, 8'h01, 8'h01, 3);
        push("t5_stat2_pre", S_STAT, 8'h04, 8'h00, 12);
        push("t5_stat2",     S_STAT, 8'h04, 8'h04, 13);
        run(16);
        pin_in[2] = 1'b0;
        push("t5_fall2",     S_FALL, 8'h04, 8'h04, 12);
        push("t5_stat2_kept",S_STAT, 8'hFF, 8'h05, 14);
        run(14);
        pin_in[2] = 1'b1;
        run(12);
        check("t5_rise_now", S_RISE, 8'h04, 8'h04);
        irq_clr = 8'h04;
        push("t5_collide",   S_STAT, 8'h04, 8'h04, 1);
        push("t5_collide2",  S_STAT, 8'h04, 8'h04, 2);
        run(1);
        irq_clr = 8'h00;
        run(2);
        irq_clr = 8'hF8;
        push("t5_clr_zero",  S_STAT, 8'hFF, 8'h05, 1);
        run(1);
        irq_clr = 8'h05;
        push("t5_clr_stat",  S_STAT, 8'hFF, 8'h00, 1);
        push("t5_clr_irq",   S_IRQ,  8'h01, 8'h00, 1);
        run(1);
        irq_clr = 8'h00;
        run(2);

        // 6. Asynchronous reset while pin 1 is mid-count.
        irq_rise_en = 8'h24;
        pin_in[5]   = 1'b1;
        push("t6_stat5", S_STAT, 8'h20, 8'h20, 4);
        run(5);
        pin_in[1] = 1'b1;
        run(9);
        check("t6_pre_gpio", S_GPIO, 8'hFF, 8'h25);
        check("t6_pre_irq",  S_IRQ,  8'h01, 8'h01);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_gpio", S_GPIO, 8'hFF, 8'h00);
        check("t6_rst_stat", S_STAT, 8'hFF, 8'h00);
        check("t6_rst_irq",  S_IRQ,  8'h01, 8'h00);
        run(2);
        check("t6_held_gpio", S_GPIO, 8'hFF, 8'h00);
        reset_n = 1'b1;
        push("t6_gpio_early", S_GPIO, 8'h02, 8'h00, 11);
        push("t6_gpio",       S_GPIO, 8'h02, 8'h02, 12);
        push("t6_rise",       S_RISE, 8'h02, 8'h02, 12);
        push("t6_rise_end",   S_RISE, 8'h02, 8'h00, 13);
        run(15);

        n_tests++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
